// File: rtl/control_unit_if.sv
// Bus between the multicycle control unit and its datapath: decoded
// instruction fields and flags in, strobes, selects and ALU control out.
interface control_unit_if;
  logic [5:0]  opCode;
  logic [5:0]  funct;
  logic        eqf;
  logic        ov;
  logic        div0;
  logic [6:0]  strobe;
  logic [3:0]  opsel;
  logic [20:0] sel;
  logic [2:0]  ALUCtrl;
  logic [4:0]  state;

  modport master (
    output opCode, funct, eqf, ov, div0,
    input  strobe, opsel, sel, ALUCtrl, state
  );

  modport slave (
    input  opCode, funct, eqf, ov, div0,
    output strobe, opsel, sel, ALUCtrl, state
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle MIPS-subset control unit (Moore FSM, PCCtrl in BRANCH follows eqf).
// Define CU_EXCEPTION_EN to enable the overflow / div0 / illegal-opcode exception path.
module control_unit (
  input  logic          clk,
  input  logic          reset,
  control_unit_if.slave bus
);

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_IR_LOAD    = 5'd3,
    S_DECODE     = 5'd4,
    S_EXEC_R     = 5'd5,
    S_WB_R       = 5'd6,
    S_EXEC_I     = 5'd7,
    S_WB_I       = 5'd8,
    S_ADDR       = 5'd9,
    S_MEM_RD     = 5'd10,
    S_MEM_WAIT   = 5'd11,
    S_WB_LW      = 5'd12,
    S_MEM_WR     = 5'd13,
    S_BRANCH     = 5'd14,
    S_JUMP       = 5'd15,
    S_MD_RUN     = 5'd16,
    S_MD_WB      = 5'd17,
    S_EXC_SAVE   = 5'd18,
    S_EXC_RD     = 5'd19,
    S_EXC_WAIT   = 5'd20,
    S_EXC_JUMP   = 5'd21
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b111;

  state_t      cur, nxt;
  logic [5:0]  md_cnt;
  logic [1:0]  exc_code;

  logic        hilo_w, epc_w, aluout_w, reg_w, ir_w, mem_w, pc_w, md_ctrl;
  logic [1:0]  iord, src_a, src_b, reg_dst, ls_ctrl, ss_ctrl, excpt;
  logic [2:0]  pc_src;
  logic [3:0]  data_src;
  logic [2:0]  alu_ctrl;
  logic        is_r_alu, is_md, r_can_ovf;
  logic [2:0]  r_alu;

  always_comb begin
    is_r_alu  = (bus.opCode == 6'h00) &&
                (bus.funct == 6'h20 || bus.funct == 6'h22 || bus.funct == 6'h24);
    is_md     = (bus.opCode == 6'h00) && (bus.funct == 6'h18 || bus.funct == 6'h1A);
    r_can_ovf = (bus.funct != 6'h24);
    case (bus.funct)
      6'h22:   r_alu = ALU_SUB;
      6'h24:   r_alu = ALU_AND;
      default: r_alu = ALU_ADD;
    endcase
  end

  // Counter is held at zero outside MD_RUN, so it is already clear on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur    <= S_RESET;
      md_cnt <= '0;
    end else begin
      cur    <= nxt;
      md_cnt <= (cur == S_MD_RUN) ? md_cnt + 6'd1 : '0;
    end
  end

`ifdef CU_EXCEPTION_EN
  logic [1:0] exc_nxt;

  always_ff @(posedge clk) begin
    if (reset)
      exc_code <= '0;
    else if (nxt == S_EXC_SAVE && cur != S_EXC_SAVE)
      exc_code <= exc_nxt;
  end
`else
  logic unused_flags;
  assign unused_flags = bus.ov ^ bus.div0;
  assign exc_code     = '0;
`endif

  always_comb begin
    nxt      = cur;
    hilo_w   = 1'b0;
    epc_w    = 1'b0;
    aluout_w = 1'b0;
    reg_w    = 1'b0;
    ir_w     = 1'b0;
    mem_w    = 1'b0;
    pc_w     = 1'b0;
    md_ctrl  = 1'b0;
    iord     = '0;
    src_a    = '0;
    src_b    = '0;
    reg_dst  = '0;
    ls_ctrl  = '0;
    ss_ctrl  = '0;
    excpt    = '0;
    pc_src   = '0;
    data_src = '0;
    alu_ctrl = '0;
`ifdef CU_EXCEPTION_EN
    exc_nxt  = '0;
`endif
    case (cur)
      S_RESET: nxt = S_FETCH;
      S_FETCH: begin
        src_b    = 2'd1;
        alu_ctrl = ALU_ADD;
        pc_w     = 1'b1;
        nxt      = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: nxt = S_IR_LOAD;
      S_IR_LOAD: begin
        ir_w = 1'b1;
        nxt  = S_DECODE;
      end
      S_DECODE: begin
        src_b    = 2'd3;
        alu_ctrl = ALU_ADD;
        aluout_w = 1'b1;
        if (is_r_alu)                                         nxt = S_EXEC_R;
        else if (is_md)                                       nxt = S_MD_RUN;
        else if (bus.opCode == 6'h08)                         nxt = S_EXEC_I;
        else if (bus.opCode == 6'h23 || bus.opCode == 6'h2B) nxt = S_ADDR;
        else if (bus.opCode == 6'h04)                         nxt = S_BRANCH;
        else if (bus.opCode == 6'h02)                         nxt = S_JUMP;
        else begin
`ifdef CU_EXCEPTION_EN
          nxt     = S_EXC_SAVE;
          exc_nxt = 2'd0;
`else
          nxt     = S_FETCH;
`endif
        end
      end
      S_EXEC_R: begin
        src_a    = 2'd1;
        alu_ctrl = r_alu;
        aluout_w = 1'b1;
        nxt      = S_WB_R;
`ifdef CU_EXCEPTION_EN
        if (bus.ov && r_can_ovf) begin
          nxt     = S_EXC_SAVE;
          exc_nxt = 2'd1;
        end
`endif
      end
      S_WB_R: begin
        reg_dst = 2'd1;
        reg_w   = 1'b1;
        nxt     = S_FETCH;
      end
      S_EXEC_I: begin
        src_a    = 2'd1;
        src_b    = 2'd2;
        alu_ctrl = ALU_ADD;
        aluout_w = 1'b1;
        nxt      = S_WB_I;
`ifdef CU_EXCEPTION_EN
        if (bus.ov) begin
          nxt     = S_EXC_SAVE;
          exc_nxt = 2'd1;
        end
`endif
      end
      S_WB_I: begin
        reg_w = 1'b1;
        nxt   = S_FETCH;
      end
      S_ADDR: begin
        src_a    = 2'd1;
        src_b    = 2'd2;
        alu_ctrl = ALU_ADD;
        aluout_w = 1'b1;
        nxt      = (bus.opCode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord = 2'd2;
        nxt  = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        iord = 2'd2;
        nxt  = S_WB_LW;
      end
      S_WB_LW: begin
        data_src = 4'd1;
        reg_w    = 1'b1;
        nxt      = S_FETCH;
      end
      S_MEM_WR: begin
        iord  = 2'd2;
        mem_w = 1'b1;
        nxt   = S_FETCH;
      end
      S_BRANCH: begin
        src_a    = 2'd1;
        alu_ctrl = ALU_CMP;
        pc_src   = 3'd1;
        pc_w     = bus.eqf;
        nxt      = S_FETCH;
      end
      S_JUMP: begin
        pc_src = 3'd2;
        pc_w   = 1'b1;
        nxt    = S_FETCH;
      end
      S_MD_RUN: begin
        md_ctrl = (bus.funct == 6'h1A);
        if (md_cnt == 6'd31) nxt = S_MD_WB;
`ifdef CU_EXCEPTION_EN
        // A divide-by-zero abort wins over the final-cycle exit to MD_WB.
        if (md_ctrl && bus.div0) begin
          nxt     = S_EXC_SAVE;
          exc_nxt = 2'd2;
        end
`endif
      end
      S_MD_WB: begin
        hilo_w = 1'b1;
        nxt    = S_FETCH;
      end
      S_EXC_SAVE: begin
        src_b    = 2'd1;
        alu_ctrl = ALU_SUB;
`ifdef CU_EXCEPTION_EN
        epc_w    = 1'b1;
`endif
        nxt      = S_EXC_RD;
      end
      S_EXC_RD: begin
        iord  = 2'd3;
        excpt = exc_code;
        nxt   = S_EXC_WAIT;
      end
      S_EXC_WAIT: begin
        iord  = 2'd3;
        excpt = exc_code;
        nxt   = S_EXC_JUMP;
      end
      S_EXC_JUMP: begin
        ls_ctrl = 2'd2;
        pc_src  = 3'd3;
        pc_w    = 1'b1;
        nxt     = S_FETCH;
      end
      default: nxt = S_RESET;
    endcase
  end

  assign bus.strobe  = {hilo_w, epc_w, aluout_w, reg_w, ir_w, mem_w, pc_w};
  assign bus.opsel   = {3'b000, md_ctrl};
  assign bus.sel     = {data_src, pc_src, excpt, ss_ctrl, ls_ctrl, reg_dst, src_b, src_a, iord};
  assign bus.ALUCtrl = alu_ctrl;
  assign bus.state   = cur;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed and random instructions traced cycle by
// cycle against a state-path / output-field reference model.
module tb_control_unit;

`ifdef CU_EXCEPTION_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   exp_q[$];
  logic [1:0] exp_code;
  int   hilo_cnt;
  int   regw_cnt;

  always #5 clk = ~clk;

  control_unit_if bus ();

  control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {strobe, opsel, sel, ALUCtrl} for a state code.
  function automatic logic [34:0] exp_out(input int st, input logic [5:0] fn,
                                          input logic eq, input logic [1:0] code);
    logic hilo, epc, aluout, regw, irw, memw, pcw, md;
    logic [1:0] iord, srca, srcb, regdst, ls, exc;
    logic [2:0] pcsrc, alu;
    logic [3:0] datasrc;
    {hilo, epc, aluout, regw, irw, memw, pcw, md} = '0;
    {iord, srca, srcb, regdst, ls, exc} = '0;
    pcsrc = '0; alu = '0; datasrc = '0;
    case (st)
      1:     begin srcb = 2'd1; alu = 3'b001; pcw = 1'b1; end
      3:     irw = 1'b1;
      4:     begin srcb = 2'd3; alu = 3'b001; aluout = 1'b1; end
      5:     begin
               srca = 2'd1; aluout = 1'b1;
               alu = (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b001;
             end
      6:     begin regdst = 2'd1; regw = 1'b1; end
      7, 9:  begin srca = 2'd1; srcb = 2'd2; alu = 3'b001; aluout = 1'b1; end
      8:     regw = 1'b1;
      10, 11: iord = 2'd2;
      12:    begin datasrc = 4'd1; regw = 1'b1; end
      13:    begin iord = 2'd2; memw = 1'b1; end
      14:    begin srca = 2'd1; alu = 3'b111; pcsrc = 3'd1; pcw = eq; end
      15:    begin pcsrc = 3'd2; pcw = 1'b1; end
      16:    md = (fn == 6'h1A);
      17:    hilo = 1'b1;
      18:    begin srcb = 2'd1; alu = 3'b010; epc = 1'b1; end
      19, 20: begin iord = 2'd3; exc = code; end
      21:    begin ls = 2'd2; pcsrc = 3'd3; pcw = 1'b1; end
      default: ;
    endcase
    return {hilo, epc, aluout, regw, irw, memw, pcw, 3'b000, md,
            datasrc, pcsrc, exc, 2'b00, ls, regdst, srcb, srca, iord, alu};
  endfunction

  // Expected state path from FETCH up to (not including) the next FETCH.
  task automatic plan(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input int d0);
    int xc;
    xc = -1;
    exp_q = {1, 2, 3, 4};
    if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24}) begin
      exp_q.push_back(5);
      if (EN && ovf && fn != 6'h24) xc = 1;
      else exp_q.push_back(6);
    end else if (op == 6'h00 && fn inside {6'h18, 6'h1A}) begin
      if (EN && fn == 6'h1A && d0 < 32) begin
        repeat (d0 + 1) exp_q.push_back(16);
        xc = 2;
      end else begin
        repeat (32) exp_q.push_back(16);
        exp_q.push_back(17);
      end
    end else if (op == 6'h08) begin
      exp_q.push_back(7);
      if (EN && ovf) xc = 1;
      else exp_q.push_back(8);
    end else if (op == 6'h23) begin
      exp_q = {exp_q, 9, 10, 11, 12};
    end else if (op == 6'h2B) begin
      exp_q = {exp_q, 9, 13};
    end else if (op == 6'h04) begin
      exp_q.push_back(14);
    end else if (op == 6'h02) begin
      exp_q.push_back(15);
    end else if (EN) begin
      xc = 0;
    end
    exp_code = (xc < 0) ? 2'd0 : xc[1:0];
    if (xc >= 0) exp_q = {exp_q, 18, 19, 20, 21};
  endtask

  // Entered at posedge+1 with the DUT in FETCH; leaves it in the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                           input logic eq, input int d0, input string tag);
    int md;
    md = 0;
    plan(op, fn, ovf, d0);
    bus.opCode = op; bus.funct = fn; bus.ov = ovf; bus.eqf = eq; bus.div0 = 1'b0;
    hilo_cnt = 0;
    regw_cnt = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i] == 16) begin
        bus.div0 = (md == d0);
        md++;
      end else begin
        bus.div0 = 1'b0;
      end
      #1;
      chk($sformatf("%s_st%0d", tag, i), 64'(bus.state), 64'(exp_q[i]));
      chk($sformatf("%s_out%0d", tag, i),
          64'({bus.strobe, bus.opsel, bus.sel, bus.ALUCtrl}),
          64'(exp_out(exp_q[i], fn, eq, exp_code)));
      if (bus.strobe[6]) hilo_cnt++;
      if (bus.strobe[3]) regw_cnt++;
      @(posedge clk);
      #1;
    end
    bus.div0 = 1'b0;
  endtask

  initial begin
    logic [5:0] op, fn;
    int pick;
    reset = 1'b1;
    bus.opCode = '0; bus.funct = '0; bus.eqf = 1'b0; bus.ov = 1'b0; bus.div0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 64'(bus.state), 64'd0);
    chk("reset_out", 64'({bus.strobe, bus.opsel, bus.sel, bus.ALUCtrl}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("first_fetch", 64'(bus.state), 64'd1);

    run_instr(6'h00, 6'h20, 1'b0, 1'b0, 99, "add");
    chk("add_regw", 64'(regw_cnt), 64'd1);
    run_instr(6'h00, 6'h22, 1'b0, 1'b1, 99, "sub");
    run_instr(6'h00, 6'h24, 1'b1, 1'b0, 99, "and_ov");
    run_instr(6'h04, 6'h00, 1'b0, 1'b1, 99, "beq_taken");
    run_instr(6'h04, 6'h00, 1'b0, 1'b0, 99, "beq_not");
    run_instr(6'h23, 6'h11, 1'b0, 1'b0, 99, "lw");
    run_instr(6'h2B, 6'h05, 1'b0, 1'b0, 99, "sw");
    run_instr(6'h02, 6'h00, 1'b0, 1'b0, 99, "jump");
    run_instr(6'h00, 6'h18, 1'b0, 1'b0, 3, "mult");
    chk("mult_len", 64'(exp_q.size()), 64'd37);
    chk("mult_hilo", 64'(hilo_cnt), 64'd1);
    run_instr(6'h00, 6'h1A, 1'b0, 1'b0, 99, "div_ok");
    chk("div_hilo", 64'(hilo_cnt), 64'd1);
    run_instr(6'h00, 6'h1A, 1'b0, 1'b0, 5, "div0_5");
    chk("div0_hilo", 64'(hilo_cnt), EN ? 64'd0 : 64'd1);
    run_instr(6'h00, 6'h1A, 1'b0, 1'b0, 31, "div0_31");
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 99, "illegal");
    run_instr(6'h08, 6'h00, 1'b1, 1'b0, 99, "addi_ov");
    chk("addi_ov_regw", 64'(regw_cnt), EN ? 64'd0 : 64'd1);
    run_instr(6'h00, 6'h20, 1'b1, 1'b0, 99, "add_ov");

    // Reset in MD_RUN cycle 10, then a complete mult.
    bus.opCode = 6'h00; bus.funct = 6'h18; bus.ov = 1'b0; bus.div0 = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("md10_state", 64'(bus.state), 64'd16);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("md_rst_state", 64'(bus.state), 64'd0);
    chk("md_rst_strobe", 64'(bus.strobe), 64'd0);
    chk("md_rst_out", 64'({bus.strobe, bus.opsel, bus.sel, bus.ALUCtrl}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("md_rst_fetch", 64'(bus.state), 64'd1);
    run_instr(6'h00, 6'h18, 1'b0, 1'b0, 99, "mult_after_rst");
    chk("mult2_hilo", 64'(hilo_cnt), 64'd1);

    for (int n = 0; n < 80; n++) begin
      pick = $urandom_range(0, 6);
      case (pick)
        0: op = 6'h00;
        1: op = 6'h08;
        2: op = 6'h23;
        3: op = 6'h2B;
        4: op = 6'h04;
        5: op = 6'h02;
        default: op = 6'($urandom);
      endcase
      pick = $urandom_range(0, 5);
      case (pick)
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h18;
        4: fn = 6'h1A;
        default: fn = 6'($urandom);
      endcase
      run_instr(op, fn, 1'($urandom), 1'($urandom), $urandom_range(0, 40),
                $sformatf("rnd%0d", n));
    end
    #1;
    chk("final_fetch", 64'(bus.state), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 opCode  input  6  instruction bits [31:26].
REQ-004 funct  input  6  instruction bits [5:0].
REQ-005 eqf  input  1  ALU equal flag.
REQ-006 ov  input  1  ALU overflow flag.
REQ-007 div0  input  1  divider divide-by-zero flag.
REQ-008 strobe  output  7  {HILOWrite, EPCCtrl, ALUOutCtrl, RegWrite, IRWrite, MemCtrl, PCCtrl}; MemCtrl 1 = write, 0 = read.
REQ-009 opsel  output  4  {ShiftAmt, ShiftSrc, SECtrl, MDCtrl}; MDCtrl 0 = mult, 1 = div; ShiftAmt, ShiftSrc and SECtrl are always 0.
REQ-010 sel  output  21  {DataSrc[3:0], PCSrc[2:0], ExcptCtrl, SSCtrl, LSCtrl, RegDst, ALUSrcB, ALUSrcA, IorD}; each unsized field is 2 bits.
REQ-011 ALUCtrl  output  3  001 add, 010 sub, 011 and, 111 compare.
REQ-012 state  output  5  current state code (debug/verification).

Function
REQ-013 State codes: RESET 0, FETCH 1, FETCH_WAIT 2, IR_LOAD 3, DECODE 4, EXEC_R 5, WB_R 6, EXEC_I 7, WB_I 8, ADDR 9, MEM_RD 10, MEM_WAIT 11, WB_LW 12, MEM_WR 13, BRANCH 14, JUMP 15, MD_RUN 16, MD_WB 17, EXC_SAVE 18, EXC_RD 19, EXC_WAIT 20, EXC_JUMP 21.
REQ-014 All outputs are decoded from the state register only (Moore); the sole exception is PCCtrl in BRANCH. Every field not named for a state is 0.
REQ-015 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=1, ALUCtrl=add, PCSrc=0, PCCtrl=1 -> FETCH_WAIT.
REQ-016 FETCH_WAIT: IorD=0 (one-cycle memory latency) -> IR_LOAD.
REQ-017 IR_LOAD: IorD=0, IRWrite=1 -> DECODE.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=3, add, ALUOutCtrl=1 (branch target).
REQ-019 DECODE dispatch on opCode/funct:
- 00/funct 20,22,24 -> EXEC_R
- 00/funct 18,1A -> MD_RUN
- 08 -> EXEC_I
- 23 or 2B -> ADDR
- 04 -> BRANCH
- 02 -> JUMP
- anything else -> EXC_SAVE, code 0
REQ-020 EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUCtrl add/sub/and per funct 20/22/24, ALUOutCtrl=1 -> WB_R; ov=1 on add/sub -> EXC_SAVE, code 1.
REQ-021 WB_R: RegDst=1, DataSrc=0, RegWrite=1 -> FETCH.
REQ-022 EXEC_I: ALUSrcA=1, ALUSrcB=2, add, ALUOutCtrl=1 -> WB_I; ov=1 -> EXC_SAVE, code 1.
REQ-023 WB_I: RegDst=0, DataSrc=0, RegWrite=1 -> FETCH.
REQ-024 ADDR: ALUSrcA=1, ALUSrcB=2, add, ALUOutCtrl=1 -> MEM_RD (opCode 23) or MEM_WR (2B).
REQ-025 MEM_RD and MEM_WAIT: IorD=2. WB_LW: LSCtrl=0 (word), DataSrc=1, RegDst=0, RegWrite=1 -> FETCH.
REQ-026 MEM_WR: IorD=2, SSCtrl=0, MemCtrl=1 -> FETCH.
REQ-027 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUCtrl=compare, PCSrc=1, PCCtrl=eqf -> FETCH.
REQ-028 JUMP: PCSrc=2, PCCtrl=1 -> FETCH.
REQ-029 MD_RUN: MDCtrl=(funct==1A). A 6-bit counter clears on entry and increments each cycle; the block stays exactly 32 cycles, then -> MD_WB.
REQ-030 During MD_RUN with div, div0=1 -> EXC_SAVE, code 2, and HILOWrite is never asserted.
REQ-031 MD_WB: HILOWrite=1 for one cycle -> FETCH.
REQ-032 Entering EXC_SAVE latches the 2-bit exception code.
REQ-033 EXC_SAVE: ALUSrcA=0, ALUSrcB=1, sub, EPCCtrl=1 (EPC = PC-4) -> EXC_RD.
REQ-034 EXC_RD and EXC_WAIT: IorD=3, ExcptCtrl=code. EXC_JUMP: LSCtrl=2 (byte), PCSrc=3, PCCtrl=1 -> FETCH.
REQ-035 An overflowing instruction never asserts RegWrite or ALUOutCtrl-dependent writeback.

Reset
REQ-036 reset=1 at an edge forces state=RESET, counter=0, exception code=0, from any state including MD_RUN and EXC_*.
REQ-037 In RESET all outputs are 0 (no PC, register or memory write); RESET -> FETCH on the first edge with reset=0.

Configuration
REQ-038 CU_EXCEPTION_EN defined: REQ-019 to REQ-034 apply in full.
REQ-039 CU_EXCEPTION_EN undefined:
- unknown opcodes go DECODE -> FETCH (NOP)
- ov and div0 are ignored
- EXC_* states are unreachable
- EPCCtrl and ExcptCtrl are constant 0

Verification
REQ-040 Assert reset during MD_RUN cycle 10 -> state=0 next edge, strobe=0, then FETCH; a following mult again spends 32 MD_RUN cycles.
REQ-041 opCode 00, funct 20, ov=0 -> state sequence 1,2,3,4,5,6,1; RegWrite=1 only in WB_R with RegDst=1.
REQ-042 opCode 04 with eqf=1 -> PCCtrl=1, PCSrc=1 in BRANCH; with eqf=0 -> PCCtrl=0 throughout BRANCH.
REQ-043 opCode 00, funct 18 -> 32 MD_RUN cycles, HILOWrite=1 for exactly one cycle, FETCH re-entered 37 cycles after the first FETCH.
REQ-044 With CU_EXCEPTION_EN, opCode 3F -> EXC_SAVE (EPCCtrl=1, ALUCtrl=010), EXC_RD (IorD=3, ExcptCtrl=0), EXC_JUMP (PCSrc=3, LSCtrl=2); without the macro -> DECODE then FETCH.
REQ-045 opCode 08 with ov=1 in EXEC_I -> EXC_SAVE with ExcptCtrl=1 in EXC_RD; RegWrite stays 0.
